// File: rtl/voting_pkg.sv
// Shared definitions for the streaming vote tally: FSM state encodings and
// small elaboration-time helpers used to size candidate and tally storage.
package voting_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Ceiling log2, bounded loop so it stays a well-behaved constant function
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of candidates for an index width n
    function automatic int ncand(input int n);
        return 1 << n;
    endfunction

    // Tally width able to hold the full vote cap 2**m
    function automatic int tally_w(input int m);
        return m + 1;
    endfunction

endpackage

// File: rtl/vote_argmax_step.sv
// One step of the running argmax: folds a single {idx,cnt} pair into the
// accumulated {best_idx,best_cnt,tie}. The first visited candidate is always
// taken so that an all-zero start cannot fake a tie.
module vote_argmax_step #(
    parameter int IDX_W    = 3,
    parameter int CNT_W    = 6,
    parameter int TIE_HIGH = 0
) (
    input  logic             first,
    input  logic [IDX_W-1:0] best_idx,
    input  logic [CNT_W-1:0] best_cnt,
    input  logic             best_tie,
    input  logic [IDX_W-1:0] idx,
    input  logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] next_idx,
    output logic [CNT_W-1:0] next_cnt,
    output logic             next_tie
);

    // Strictly larger wins and clears tie; equal sets tie and moves only when ties go high
    always_comb begin
        next_idx = best_idx;
        next_cnt = best_cnt;
        next_tie = best_tie;
        if (first || (cnt > best_cnt)) begin
            next_idx = idx;
            next_cnt = cnt;
            next_tie = 1'b0;
        end else if (cnt == best_cnt) begin
            next_tie = 1'b1;
            if (TIE_HIGH != 0) begin
                next_idx = idx;
            end
        end
    end

endmodule

// File: rtl/voting_stream_tally.sv
// Streaming plurality vote counter. Votes arrive over valid/ready and are
// tallied per candidate; at round end the tallies are scanned one candidate
// per cycle and the winner, its count, a tie flag and a forced-close flag are
// held on a valid/ready result port until accepted.
module voting_stream_tally
    import voting_pkg::*;
#(
    parameter int N        = 3,
    parameter int M        = 5,
    parameter int TIE_HIGH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vote_valid,
    output logic         vote_ready,
    input  logic [N-1:0] vote_data,
    input  logic         vote_last,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count,
    output logic         tie,
    output logic         forced
);

    localparam int NC = ncand(N);
    localparam int TW = tally_w(M);
    localparam int SW = clog2(NC) + 1;

    localparam logic [TW-1:0] CAP      = {1'b1, {M{1'b0}}};
    localparam logic [SW-1:0] SCAN_END = SW'(NC);

    state_t         state_q, state_d;
    logic [TW-1:0]  tally_q [NC];
    logic [TW-1:0]  tally_d [NC];
    logic [TW-1:0]  total_q, total_d;
    logic [SW-1:0]  scan_idx_q, scan_idx_d;
    logic [N-1:0]   best_idx_q, best_idx_d;
    logic [TW-1:0]  best_cnt_q, best_cnt_d;
    logic           best_tie_q, best_tie_d;
    logic           forced_pend_q, forced_pend_d;
    logic           result_valid_q, result_valid_d;
    logic [N-1:0]   winner_q, winner_d;
    logic [TW-1:0]  winner_count_q, winner_count_d;
    logic           tie_q, tie_d;
    logic           forced_q, forced_d;

    logic [N-1:0]   step_idx;
    logic [TW-1:0]  step_cnt;
    logic           step_tie;
    logic [N-1:0]   visit_idx;

    assign visit_idx = scan_idx_q[N-1:0];

    vote_argmax_step #(
        .IDX_W    (N),
        .CNT_W    (TW),
        .TIE_HIGH (TIE_HIGH)
    ) u_step (
        .first    (scan_idx_q == '0),
        .best_idx (best_idx_q),
        .best_cnt (best_cnt_q),
        .best_tie (best_tie_q),
        .idx      (visit_idx),
        .cnt      (tally_q[visit_idx]),
        .next_idx (step_idx),
        .next_cnt (step_cnt),
        .next_tie (step_tie)
    );

    // Next-state logic: tally votes, walk the tallies, then hold the result until taken
    always_comb begin
        state_d        = state_q;
        tally_d        = tally_q;
        total_d        = total_q;
        scan_idx_d     = scan_idx_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        best_tie_d     = best_tie_q;
        forced_pend_d  = forced_pend_q;
        result_valid_d = result_valid_q;
        winner_d       = winner_q;
        winner_count_d = winner_count_q;
        tie_d          = tie_q;
        forced_d       = forced_q;

        case (state_q)
            ST_COLLECT: begin
                if (vote_valid) begin
                    tally_d[vote_data] = tally_q[vote_data] + TW'(1);
                    total_d            = total_q + TW'(1);
                    if (vote_last || (total_d == CAP)) begin
                        state_d       = ST_SCAN;
                        scan_idx_d    = '0;
                        forced_pend_d = !vote_last;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_idx_q != SCAN_END) begin
                    best_idx_d = step_idx;
                    best_cnt_d = step_cnt;
                    best_tie_d = step_tie;
                    scan_idx_d = scan_idx_q + SW'(1);
                end else begin
                    winner_d       = best_idx_q;
                    winner_count_d = best_cnt_q;
                    tie_d          = best_tie_q;
                    forced_d       = forced_pend_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    for (int i = 0; i < NC; i++) begin
                        tally_d[i] = '0;
                    end
                    total_d        = '0;
                    result_valid_d = 1'b0;
                    state_d        = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and output registers; reset discards any round in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            for (int i = 0; i < NC; i++) begin
                tally_q[i] <= '0;
            end
            total_q        <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            best_tie_q     <= 1'b0;
            forced_pend_q  <= 1'b0;
            result_valid_q <= 1'b0;
            winner_q       <= '0;
            winner_count_q <= '0;
            tie_q          <= 1'b0;
            forced_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            tally_q        <= tally_d;
            total_q        <= total_d;
            scan_idx_q     <= scan_idx_d;
            best_idx_q     <= best_idx_d;
            best_cnt_q     <= best_cnt_d;
            best_tie_q     <= best_tie_d;
            forced_pend_q  <= forced_pend_d;
            result_valid_q <= result_valid_d;
            winner_q       <= winner_d;
            winner_count_q <= winner_count_d;
            tie_q          <= tie_d;
            forced_q       <= forced_d;
        end
    end

    assign vote_ready   = (state_q == ST_COLLECT);
    assign result_valid = result_valid_q;
    assign winner       = winner_q;
    assign winner_count = winner_count_q;
    assign tie          = tie_q;
    assign forced       = forced_q;

endmodule

// File: tb/tb_voting_stream_tally.sv
// Scoreboard bench for voting_stream_tally. Three instances cover the default
// configuration, high tie-break and a small vote cap. Expected results are
// queued when a round is issued; a monitor pops and compares on each result
// handshake and also checks result latency after the last accepted vote.
module tb_voting_stream_tally;

    typedef struct {
        int dut;
        int win;
        int cnt;
        int tie;
        int forced;
    } exp_t;

    logic clk;
    logic rst_n;
    logic       vv [3];
    logic [2:0] vd [3];
    logic       vl [3];
    logic       rr [3];

    logic       vr [3];
    logic       rv [3];
    logic [2:0] win [3];
    logic [5:0] wc [3];
    logic       tie_o [3];
    logic       forced_o [3];

    logic       vr0, vr1, vr2, rv0, rv1, rv2;
    logic [2:0] win0, win1, win2;
    logic [5:0] wc0, wc1;
    logic [2:0] wc2;
    logic       tie0, tie1, tie2, fo0, fo1, fo2;

    exp_t sbQ[$];
    int   compares = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lastAcc [3];
    logic prevRv [3];

    voting_stream_tally #(.N(3), .M(5), .TIE_HIGH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .vote_valid(vv[0]), .vote_ready(vr0),
        .vote_data(vd[0]), .vote_last(vl[0]), .result_valid(rv0),
        .result_ready(rr[0]), .winner(win0), .winner_count(wc0),
        .tie(tie0), .forced(fo0));

    voting_stream_tally #(.N(3), .M(5), .TIE_HIGH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .vote_valid(vv[1]), .vote_ready(vr1),
        .vote_data(vd[1]), .vote_last(vl[1]), .result_valid(rv1),
        .result_ready(rr[1]), .winner(win1), .winner_count(wc1),
        .tie(tie1), .forced(fo1));

    voting_stream_tally #(.N(3), .M(2), .TIE_HIGH(0)) u2 (
        .clk(clk), .rst_n(rst_n), .vote_valid(vv[2]), .vote_ready(vr2),
        .vote_data(vd[2]), .vote_last(vl[2]), .result_valid(rv2),
        .result_ready(rr[2]), .winner(win2), .winner_count(wc2),
        .tie(tie2), .forced(fo2));

    // Gather per-instance outputs into arrays so stimulus and monitor can loop
    always_comb begin
        vr[0] = vr0;  vr[1] = vr1;  vr[2] = vr2;
        rv[0] = rv0;  rv[1] = rv1;  rv[2] = rv2;
        win[0] = win0; win[1] = win1; win[2] = win2;
        wc[0] = wc0;  wc[1] = wc1;  wc[2] = {3'b000, wc2};
        tie_o[0] = tie0; tie_o[1] = tie1; tie_o[2] = tie2;
        forced_o[0] = fo0; forced_o[1] = fo1; forced_o[2] = fo2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Present one vote and hold it until the DUT accepts it (bounded)
    task automatic applyStimulus(input int d, input logic [2:0] data, input logic last);
        int n;
        vv[d] = 1'b1;
        vd[d] = data;
        vl[d] = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vr[d] && n < 200);
        if (!vr[d]) checkOutput("vote_accept_timeout", 32'(vr[d]), 32'd1);
        @(posedge clk);
        #1;
        vv[d] = 1'b0;
        vl[d] = 1'b0;
    endtask

    // Wait (bounded) for a result to appear, then step past the next edge
    task automatic waitResult(input int d);
        int n;
        n = 0;
        while (!rv[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result_seen", 32'(rv[d]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int d, input int w, input int c, input int t, input int f);
        exp_t e;
        e.dut = d; e.win = w; e.cnt = c; e.tie = t; e.forced = f;
        sbQ.push_back(e);
    endtask

    // Monitor: latency on result rise, scoreboard compare on each result handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) prevRv[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (vv[d] && vr[d]) lastAcc[d] = cyc + 1;
                if (rv[d] && !prevRv[d]) checkOutput("latency", 32'(cyc - lastAcc[d]), 32'd9);
                if (rv[d] && rr[d]) begin
                    checkOutput("result_expected", 32'(sbQ.size() != 0), 32'd1);
                    if (sbQ.size() != 0) begin
                        e = sbQ.pop_front();
                        checkOutput("result_dut", 32'(d), 32'(e.dut));
                        checkOutput("winner", 32'(win[d]), 32'(e.win));
                        checkOutput("winner_count", 32'(wc[d]), 32'(e.cnt));
                        checkOutput("tie", 32'(tie_o[d]), 32'(e.tie));
                        checkOutput("forced", 32'(forced_o[d]), 32'(e.forced));
                    end
                end
                prevRv[d] = rv[d];
            end
        end
    end

    // Global guard so the bench always ends
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got 1 expected 0");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence
    initial begin
        logic [2:0] stream [32];
        int acc;
        stream = '{3'd5,3'd7,3'd5,3'd4,3'd0,3'd7,3'd0,3'd5,3'd3,3'd3,3'd1,3'd2,3'd2,3'd1,3'd4,3'd2,
                   3'd3,3'd5,3'd6,3'd0,3'd5,3'd5,3'd7,3'd1,3'd6,3'd3,3'd5,3'd5,3'd3,3'd1,3'd7,3'd2};
        for (int d = 0; d < 3; d++) begin
            vv[d] = 1'b0; vd[d] = '0; vl[d] = 1'b0; rr[d] = 1'b1;
            lastAcc[d] = 0; prevRv[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_result_valid", 32'(rv[d]), 32'd0);
            checkOutput("rst_winner", 32'(win[d]), 32'd0);
            checkOutput("rst_winner_count", 32'(wc[d]), 32'd0);
            checkOutput("rst_tie", 32'(tie_o[d]), 32'd0);
            checkOutput("rst_forced", 32'(forced_o[d]), 32'd0);
            checkOutput("rst_vote_ready", 32'(vr[d]), 32'd1);
        end
        @(posedge clk);
        #1;

        $display("[TB] full 32-vote round");
        pushExp(0, 5, 8, 0, 0);
        for (int i = 0; i < 32; i++) applyStimulus(0, stream[i], i == 31);
        waitResult(0);

        $display("[TB] tie low with result backpressure");
        rr[0] = 1'b0;
        pushExp(0, 2, 2, 1, 0);
        applyStimulus(0, 3'd2, 1'b0);
        applyStimulus(0, 3'd6, 1'b0);
        applyStimulus(0, 3'd2, 1'b0);
        applyStimulus(0, 3'd6, 1'b1);
        waitResult(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_stable", {19'd0, rv[0], vr[0], win[0], wc[0], tie_o[0], forced_o[0]},
                        {19'd0, 1'b1, 1'b0, 3'd2, 6'd2, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        rr[0] = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single vote after cleared tallies");
        pushExp(0, 4, 1, 0, 0);
        applyStimulus(0, 3'd4, 1'b1);
        waitResult(0);

        $display("[TB] tie high");
        pushExp(1, 6, 2, 1, 0);
        applyStimulus(1, 3'd2, 1'b0);
        applyStimulus(1, 3'd6, 1'b0);
        applyStimulus(1, 3'd2, 1'b0);
        applyStimulus(1, 3'd6, 1'b1);
        waitResult(1);

        $display("[TB] vote cap");
        pushExp(2, 3, 4, 0, 1);
        acc = 0;
        vv[2] = 1'b1; vd[2] = 3'd3; vl[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vr[2]) acc++;
            if (i >= 4) checkOutput("cap_ready_low", 32'(vr[2]), 32'd0);
            @(posedge clk);
            #1;
        end
        vv[2] = 1'b0;
        checkOutput("cap_accepted", 32'(acc), 32'd4);
        waitResult(2);
        pushExp(2, 1, 1, 0, 0);
        applyStimulus(2, 3'd1, 1'b1);
        waitResult(2);

        $display("[TB] gapped input");
        pushExp(0, 1, 2, 0, 0);
        applyStimulus(0, 3'd1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 3'd1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 3'd0, 1'b1);
        waitResult(0);

        $display("[TB] reset during scan");
        applyStimulus(0, 3'd3, 1'b0);
        applyStimulus(0, 3'd3, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_vote_ready", 32'(vr[0]), 32'd1);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv[0]) acc++;
        end
        checkOutput("post_rst_no_result", 32'(acc), 32'd0);
        @(posedge clk);
        #1;
        pushExp(0, 7, 1, 0, 0);
        applyStimulus(0, 3'd7, 1'b1);
        waitResult(0);

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
        $finish;
    end

endmodule
